// File: rtl/seq_mul8_pkg.sv
// Shared ALU package: FSM state encoding and default operand width for the
// sequential shift-add multiplier.
package seq_mul8_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul8_adder.sv
// N-bit ripple-carry adder built from a chain of full-adder cells; used as the
// single step adder of the shift-add multiplier.
module Adder_N #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_mul8.sv
// Sequential unsigned N x N multiplier: one shift-add step per BUSY cycle,
// product held in {p_hi, p_lo} and presented through a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. io_in_ready is high only in IDLE and io_out_valid only in DONE; once
// io_out_valid rises, io_out_bits stays constant until the transfer edge.
module seq_mul8
  import seq_mul8_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           io_in_valid,
  output logic           io_in_ready,
  input  logic [N-1:0]   io_in_a,
  input  logic [N-1:0]   io_in_b,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [2*N-1:0] io_out_bits,
  output logic [1:0]     fsm_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  p_hi;
  logic [N-1:0]  p_lo;
  logic [CW-1:0] cnt;

  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic          cout;

  // The multiplier bit under examination sits in p_lo[0]; it gates the addend.
  assign addend = p_lo[0] ? a_reg : '0;

  Adder_N #(
    .N(N)
  ) u_adder (
    .a   (addend),
    .b   (p_hi),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      a_reg        <= '0;
      p_hi         <= '0;
      p_lo         <= '0;
      cnt          <= '0;
      io_in_ready  <= 1'b1;
      io_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            a_reg       <= io_in_a;
            p_hi        <= '0;
            p_lo        <= io_in_b;
            cnt         <= '0;
            state       <= BUSY;
            io_in_ready <= 1'b0;
          end
        end
        BUSY: begin
          // Shift the N+1-bit partial sum right by one into the product register.
          p_hi <= {cout, sum[N-1:1]};
          p_lo <= {sum[0], p_lo[N-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            state        <= DONE;
            io_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            state        <= IDLE;
            io_out_valid <= 1'b0;
            io_in_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          io_out_valid <= 1'b0;
          io_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign io_out_bits = {p_hi, p_lo};
  assign fsm_state   = state;

endmodule

// File: doc/seq_mul8.md
SEQ_MUL8 -- requirements
Module: seq_mul8

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the operand width in bits.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port io_in_valid, input, 1 bit: upstream operands are valid.
REQ-005 The module SHALL have port io_in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The module SHALL have port io_in_a, input, N bits: unsigned multiplicand.
REQ-007 The module SHALL have port io_in_b, input, N bits: unsigned multiplier.
REQ-008 The module SHALL have port io_out_valid, output, 1 bit: the product is valid.
REQ-009 The module SHALL have port io_out_ready, input, 1 bit: downstream accepts the product.
REQ-010 The module SHALL have port io_out_bits, output, 2N bits: unsigned product.

Function
REQ-011 The block SHALL compute io_in_a * io_in_b as an unsigned shift-add product, with exact 2N-bit width and no truncation.
REQ-012 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-013 io_in_ready SHALL be 1 only in IDLE; io_out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, an edge with io_in_valid=1 SHALL accept the operands: A<=io_in_a, P_hi<=0, P_lo<=io_in_b, cnt<=0, state->BUSY.
REQ-015 In IDLE with io_in_valid=0, all registers SHALL hold their values.
REQ-016 Each BUSY edge SHALL perform one step: {c,s} = P_hi + (P_lo[0] ? A : 0), with carry-in 0 and N-bit add plus carry-out.
REQ-017 Each BUSY step SHALL then update P_hi<={c,s[N-1:1]}, P_lo<={s[0],P_lo[N-1:1]} and cnt<=cnt+1.
REQ-018 When cnt=N-1 on a BUSY edge, that step SHALL be the last step and state SHALL go to DONE.
REQ-019 io_out_valid SHALL rise exactly N edges after the accepting edge (8 for the default), with no early or late completion.
REQ-020 io_out_bits SHALL equal {P_hi,P_lo} at all times and SHALL be stable throughout DONE.
REQ-021 In DONE, an edge with io_out_ready=1 SHALL complete the handshake and return the state to IDLE.
REQ-022 In DONE with io_out_ready=0, all registers SHALL hold for an unbounded time.
REQ-023 io_in_valid SHALL be ignored outside IDLE; operand changes during BUSY or DONE SHALL not affect the result.
REQ-024 A new operand SHALL be accepted no earlier than the edge after the output handshake, giving a minimum initiation interval of N+2 cycles.
REQ-025 cnt SHALL be ceil(log2 N) bits wide and SHALL never wrap during a valid operation.

Reset
REQ-026 Reset SHALL be sampled synchronously and override all other activity on the same edge.
REQ-027 After reset: state=IDLE, io_in_ready=1, io_out_valid=0, io_out_bits=0, cnt=0, A=0.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation; the in-flight product SHALL be discarded and never presented.

Structure
REQ-029 The FSM state enumeration (IDLE, BUSY, DONE) and the default width constant (8) SHALL live in the shared ALU package.
REQ-030 The step addition SHALL use one instance of the team's existing N-bit ripple-carry adder (Adder_N) as the sole sub-module.
REQ-031 The Adder_N instance SHALL take A-or-0 and P_hi as operands with carry-in tied to 0; Sum and Cout SHALL feed the shift.
REQ-032 No other arithmetic operator SHALL appear on the datapath.

Verification
REQ-033 Accept a=13, b=11 -> io_out_valid rises 8 edges after acceptance with io_out_bits=143 (0x008F); handshake -> IDLE.
REQ-034 Accept a=255, b=255 (exercises carry-out every step) -> io_out_bits=65025 (0xFE01).
REQ-035 Accept a=0, b=200 and then a=200, b=0 -> both products equal 0, each with 8-cycle latency.
REQ-036 Hold io_out_ready=0 for 5 cycles in DONE, with io_in_valid=1 and a=b=0xFF driven meanwhile -> io_out_bits stays stable, io_in_ready stays 0, and the original product is delivered.
REQ-037 Assert reset for 1 cycle at step 4 of BUSY -> next cycle state=IDLE, io_in_ready=1, io_out_valid=0, io_out_bits=0; a following a=3, b=5 -> 15.
REQ-038 Run 1000 random back-to-back operations with random out-ready stalls -> every product matches the scoreboard, with none lost or duplicated.
